multiciclo_control: RTL

Multicycle MIPS control unit: a Moore-style FSM, with write enables gated by `mem_ready`, that sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and write-back steps. It replaces the single-cycle `control` block when the processor moves to the multicycle datapath. It drives every datapath mux select and write enable, plus the 4-bit ALU operation. It supports R-type (add/sub/and/or/slt/nor), lw, sw, beq, j and addi, and waits on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 26 ++
 rtl/multiciclo_control.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Purpose : shared encodings for the multicycle MIPS control unit (states,
//           opcodes, funct codes, ALU operations, mux selects).
// Latency : n/a (types and constants only). Backpressure: n/a.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Purpose : funct -> ALU operation map plus a legality flag for R-type decode.
// Latency : combinational. Backpressure: none.
// Ports   : i_funct (6) in; o_operation (4), o_funct_legal (1) out.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_operation,
  output logic       o_funct_legal
);

  always_comb begin
    o_operation   = ALU_ADD;
    o_funct_legal = 1'b1;
    case (i_funct)
      FN_ADD:  o_operation = ALU_ADD;
      FN_SUB:  o_operation = ALU_SUB;
      FN_AND:  o_operation = ALU_AND;
      FN_OR:   o_operation = ALU_OR;
      FN_SLT:  o_operation = ALU_SLT;
      FN_NOR:  o_operation = ALU_NOR;
      default: o_funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multiciclo_control.sv
// Purpose : Moore FSM sequencing the multicycle MIPS datapath (fetch, decode,
//           execute, memory, write-back); drives all selects, enables, ALU op.
// Latency : 3-5 cycles per instruction; stalls one cycle per mem_ready=0 in
//           FETCH / MEM_RD / MEM_WR. Write enables are held 0 while rst is low.
// Ports   : clk, rst (async active-low), op_code, funct_field, mem_ready in;
//           datapath controls, operation, instr_done, illegal_op, state out.
module multiciclo_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic [5:0] funct_field,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] operation,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_alu_op;
  logic       w_funct_legal;

  alu_decoder u_alu_decoder (
    .i_funct       (funct_field),
    .o_operation   (w_alu_op),
    .o_funct_legal (w_funct_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next      = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    operation   = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm << 2) so BRANCH can use ALUOut.
        ALUSrcB = SRCB_IMMSH2;
        case (op_code)
          OP_RTYPE: begin
            if (w_funct_legal) w_next = S_EXEC;
            else               illegal_op = 1'b1;
          end
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = (op_code == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        w_next     = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        operation = w_alu_op;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        operation   = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // During reset the state already reads FETCH; only the enables and
    // pulses need suppressing so nothing is written while rst is low.
    if (!rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule
